// File: rtl/sd_io_arbiter.sv
// Round-robin arbiter that shares one host sector-transfer channel among NUM_DEV
// sd_card emulators: synchronizes their requests, routes ack/strobes, flags errors.
module sd_io_arbiter #(
  parameter int  NUM_DEV        = 2,
  parameter int  SECTOR_BYTES   = 512,
  parameter int  TIMEOUT_CYCLES = 1048576,
  localparam int GW             = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NUM_DEV-1:0]    dev_rd,
  input  logic [NUM_DEV-1:0]    dev_wr,
  input  logic [32*NUM_DEV-1:0] dev_lba,
  output logic [NUM_DEV-1:0]    dev_ack,
  input  logic [8*NUM_DEV-1:0]  dev_dout,
  output logic [NUM_DEV-1:0]    dev_din_strobe,
  output logic [NUM_DEV-1:0]    dev_dout_strobe,
  output logic                  host_rd,
  output logic                  host_wr,
  output logic [31:0]           host_lba,
  output logic [GW-1:0]         host_dev,
  input  logic                  host_ack,
  input  logic                  host_din_strobe,
  input  logic                  host_dout_strobe,
  output logic [7:0]            host_dout,
  output logic                  short_err,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam int CW = $clog2(SECTOR_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RELEASE} state_t;

  state_t               r_state, w_next;
  logic [NUM_DEV-1:0]   r_rd_s1, r_rd_s2, r_wr_s1, r_wr_s2;
  logic [NUM_DEV-1:0]   w_pend, w_grant_1h, r_dev_ack;
  logic [GW-1:0]        r_grant, r_last, w_pick;
  logic                 w_found, w_pick_rd, w_g_rd, w_g_wr;
  logic [31:0]          w_pick_lba, r_lba;
  logic [7:0]           w_g_dout;
  logic [CW-1:0]        r_byte_cnt;
  logic [TW-1:0]        r_to_cnt;
  logic                 r_host_rd, r_host_wr, r_short, r_timeout;
  logic                 w_xfer, w_strobe, w_short_set, w_to_set;

  // Round-robin search: walking offsets downward lets the nearest pending index win.
  always_comb begin
    w_pend  = r_rd_s2 | r_wr_s2;
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = NUM_DEV; k >= 1; k--) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        if ((i == (int'(r_last) + k) % NUM_DEV) && w_pend[i]) begin
          w_found = 1'b1;
          w_pick  = GW'(i);
        end
      end
    end
  end

  always_comb begin
    w_g_rd     = 1'b0;
    w_g_wr     = 1'b0;
    w_g_dout   = 8'h00;
    w_grant_1h = '0;
    w_pick_lba = 32'h0;
    w_pick_rd  = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (GW'(i) == r_grant) begin
        w_g_rd        = r_rd_s2[i];
        w_g_wr        = r_wr_s2[i];
        w_g_dout      = dev_dout[8*i +: 8];
        w_grant_1h[i] = 1'b1;
      end
      if (GW'(i) == w_pick) begin
        w_pick_lba = dev_lba[32*i +: 32];
        w_pick_rd  = r_rd_s2[i];
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // RELEASE holds until the granted device's own request has drained through the synchronizer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_found)            w_next = S_REQ;
      S_REQ:     if (host_ack)           w_next = S_XFER;
      S_XFER:    if (!host_ack)          w_next = S_RELEASE;
      S_RELEASE: if (!w_g_rd && !w_g_wr) w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  assign w_xfer      = (r_state == S_XFER);
  assign w_strobe    = host_din_strobe | host_dout_strobe;
  assign w_short_set = w_xfer && !host_ack && (r_byte_cnt != CW'(SECTOR_BYTES));
  assign w_to_set    = (r_state == S_REQ) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_rd_s1    <= '0;
      r_rd_s2    <= '0;
      r_wr_s1    <= '0;
      r_wr_s2    <= '0;
      r_grant    <= '0;
      r_last     <= GW'(NUM_DEV - 1);
      r_lba      <= 32'h0;
      r_host_rd  <= 1'b0;
      r_host_wr  <= 1'b0;
      r_dev_ack  <= '0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      r_short    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_rd_s1 <= dev_rd;
      r_rd_s2 <= r_rd_s1;
      r_wr_s1 <= dev_wr;
      r_wr_s2 <= r_wr_s1;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant   <= w_pick;
            r_lba     <= w_pick_lba;
            r_host_rd <= w_pick_rd;
            r_host_wr <= !w_pick_rd;
            r_to_cnt  <= '0;
          end
        end
        S_REQ: begin
          if (r_to_cnt != TW'(TIMEOUT_CYCLES)) r_to_cnt <= r_to_cnt + 1'b1;
          if (host_ack) begin
            r_host_rd  <= 1'b0;
            r_host_wr  <= 1'b0;
            r_byte_cnt <= '0;
            r_dev_ack  <= w_grant_1h;
          end
        end
        S_XFER: begin
          if (w_strobe && (r_byte_cnt != CW'(SECTOR_BYTES))) r_byte_cnt <= r_byte_cnt + 1'b1;
          if (!host_ack) r_dev_ack <= '0;
        end
        S_RELEASE: begin
          if (!w_g_rd && !w_g_wr) r_last <= r_grant;
        end
        default: ;
      endcase
      // A set in the same cycle as err_clr takes precedence.
      if (w_short_set)  r_short <= 1'b1;
      else if (err_clr) r_short <= 1'b0;
      if (w_to_set)     r_timeout <= 1'b1;
      else if (err_clr) r_timeout <= 1'b0;
    end
  end

  assign dev_ack         = r_dev_ack;
  assign dev_din_strobe  = (w_xfer && host_din_strobe)  ? w_grant_1h : '0;
  assign dev_dout_strobe = (w_xfer && host_dout_strobe) ? w_grant_1h : '0;
  assign host_dout       = w_xfer ? w_g_dout : 8'h00;
  assign host_rd         = r_host_rd;
  assign host_wr         = r_host_wr;
  assign host_lba        = r_lba;
  assign host_dev        = r_grant;
  assign short_err       = r_short;
  assign timeout_err     = r_timeout;

endmodule

// File: tb/tb_sd_io_arbiter.sv
// Randomized scoreboard bench for sd_io_arbiter: a round-robin model predicts grants
// and per-transfer byte counts; a monitor checks them plus routing on every cycle.
module tb_sd_io_arbiter;
  localparam int NDEV = 2;
  localparam int SB   = 512;
  localparam int TO   = 16;
  localparam int DW   = 8 * NDEV;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [NDEV-1:0]   dev_rd, dev_wr, dev_ack, dev_din_strobe, dev_dout_strobe;
  logic [32*NDEV-1:0] dev_lba;
  logic [DW-1:0]     dev_dout;
  logic              host_rd, host_wr, host_ack, host_din_strobe, host_dout_strobe;
  logic [31:0]       host_lba;
  logic [0:0]        host_dev;
  logic [7:0]        host_dout;
  logic              short_err, timeout_err, err_clr;

  sd_io_arbiter #(.NUM_DEV(NDEV), .SECTOR_BYTES(SB), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_lba(dev_lba), .dev_ack(dev_ack),
    .dev_dout(dev_dout), .dev_din_strobe(dev_din_strobe), .dev_dout_strobe(dev_dout_strobe),
    .host_rd(host_rd), .host_wr(host_wr), .host_lba(host_lba), .host_dev(host_dev),
    .host_ack(host_ack), .host_din_strobe(host_din_strobe), .host_dout_strobe(host_dout_strobe),
    .host_dout(host_dout), .short_err(short_err), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { int dev; logic [31:0] lba; bit rd; } grant_t;
  typedef struct { int dev; int nbytes; } xfer_t;

  grant_t      exp_grants[$];
  xfer_t       exp_xfers[$];
  int          errors = 0;
  int          checks = 0;
  int          m_last;
  bit          m_rd  [NDEV];
  logic [31:0] m_lba [NDEV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #2;
    dev_dout = DW'($urandom);
  endtask

  function automatic int rr_pick(input int last, input int pend);
    for (int k = 1; k <= NDEV; k++)
      if (((pend >> ((last + k) % NDEV)) & 1) != 0) return (last + k) % NDEV;
    return 0;
  endfunction

  task automatic request(input int d, input bit rd, input logic [31:0] lba);
    m_rd[d]  = rd;
    m_lba[d] = lba;
    dev_lba[32*d +: 32] = lba;
    if (rd) dev_rd[d] = 1'b1;
    else    dev_wr[d] = 1'b1;
  endtask

  task automatic expect_grant(output int d);
    int pend;
    pend = int'(dev_rd | dev_wr);
    d = rr_pick(m_last, pend);
    exp_grants.push_back('{dev: d, lba: m_lba[d], rd: m_rd[d]});
    m_last = d;
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!(host_rd || host_wr) && n < 200) begin
      tick();
      n++;
    end
    ok = (n < 200);
    if (!ok) fail_event("wait_host_request timeout");
  endtask

  task automatic strobes(input int d, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (m_rd[d]) host_din_strobe = 1'b1;
      else         host_dout_strobe = 1'b1;
      tick();
      host_din_strobe  = 1'b0;
      host_dout_strobe = 1'b0;
      repeat ($urandom_range(0, 1)) tick();
    end
  endtask

  task automatic serve(input int d, input int nbytes, input int ack_dly, input bit drop);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    exp_xfers.push_back('{dev: d, nbytes: nbytes});
    repeat (ack_dly) tick();
    host_ack = 1'b1;
    tick();
    if (drop) begin
      dev_rd[d] = 1'b0;
      dev_wr[d] = 1'b0;
    end
    strobes(d, nbytes);
    host_ack = 1'b0;
    tick();
  endtask

  // Monitor: grant presentations, transfer ends and per-cycle routing.
  initial begin
    grant_t          g;
    xfer_t           x;
    logic            prev_req;
    logic [NDEV-1:0] prev_ack, one, exp_mask, exp_din, exp_dout;
    logic [7:0]      exp_hd;
    int              cnt [NDEV];
    int              cur;
    prev_req = 1'b0;
    prev_ack = '0;
    one      = 1;
    cur      = -1;
    for (int i = 0; i < NDEV; i++) cnt[i] = 0;
    forever begin
      @(negedge clk_sys);
      if ((host_rd || host_wr) && !prev_req) begin
        if (exp_grants.size() == 0) fail_event("unexpected_grant");
        else begin
          g   = exp_grants.pop_front();
          cur = g.dev;
          check("grant_dev", 32'(host_dev), 32'(g.dev));
          check("grant_lba", host_lba, g.lba);
          check("grant_rd",  32'(host_rd), 32'(g.rd));
          check("grant_wr",  32'(host_wr), 32'(!g.rd));
        end
      end
      check("rd_wr_exclusive", 32'(host_rd && host_wr), 32'(0));
      exp_mask = (cur >= 0) ? (one << cur) : '0;
      check("ack_to_other", 32'(dev_ack & ~exp_mask), 32'(0));
      exp_din  = '0;
      exp_dout = '0;
      exp_hd   = 8'h00;
      if (cur >= 0 && dev_ack == exp_mask) begin
        exp_din  = host_din_strobe  ? exp_mask : '0;
        exp_dout = host_dout_strobe ? exp_mask : '0;
        exp_hd   = dev_dout[8*cur +: 8];
      end
      check("din_route",  32'(dev_din_strobe),  32'(exp_din));
      check("dout_route", 32'(dev_dout_strobe), 32'(exp_dout));
      check("host_dout",  32'(host_dout),       32'(exp_hd));
      for (int i = 0; i < NDEV; i++) begin
        if (dev_din_strobe[i] || dev_dout_strobe[i]) cnt[i]++;
        if (prev_ack[i] && !dev_ack[i]) begin
          if (exp_xfers.size() == 0) fail_event("unexpected_xfer_end");
          else begin
            x = exp_xfers.pop_front();
            check("xfer_dev",   32'(i),      32'(x.dev));
            check("xfer_bytes", 32'(cnt[i]), 32'(x.nbytes));
          end
          cnt[i] = 0;
        end
      end
      prev_req = host_rd || host_wr;
      prev_ack = dev_ack;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit ok;
    dev_rd = '0; dev_wr = '0; dev_lba = '0; dev_dout = '0;
    host_ack = 1'b1; host_din_strobe = 1'b1; host_dout_strobe = 1'b1; err_clr = 1'b0;
    m_last = NDEV - 1;
    for (int i = 0; i < NDEV; i++) begin m_rd[i] = 1'b0; m_lba[i] = 32'h0; end
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #2;
    check("rst_host_rd",  32'(host_rd), 32'(0));
    check("rst_host_wr",  32'(host_wr), 32'(0));
    check("rst_host_lba", host_lba, 32'(0));
    check("rst_dev_ack",  32'(dev_ack), 32'(0));
    check("rst_din_stb",  32'(dev_din_strobe), 32'(0));
    check("rst_errs",     32'({short_err, timeout_err}), 32'(0));
    reset = 1'b0;
    repeat (3) tick();
    check("idle_ack_glitch_ack", 32'(dev_ack), 32'(0));
    check("idle_ack_glitch_stb", 32'(dev_din_strobe | dev_dout_strobe), 32'(0));
    host_ack = 1'b0; host_din_strobe = 1'b0; host_dout_strobe = 1'b0;
    tick();

    // Single read with latency check
    request(0, 1'b1, 32'h1234);
    expect_grant(d);
    tick(); tick();
    check("latency_edge2", 32'(host_rd), 32'(0));
    tick();
    check("latency_edge3", 32'(host_rd), 32'(1));
    check("single_lba", host_lba, 32'h1234);
    serve(d, SB, 2, 1'b1);
    check("single_short", 32'(short_err), 32'(0));

    // Fairness: alternating read/write requesters
    request(0, 1'b1, $urandom);
    request(1, 1'b0, $urandom);
    for (int it = 0; it < 4; it++) begin
      expect_grant(d);
      serve(d, SB, $urandom_range(0, 3), 1'b1);
      if (it < 2) request(d, m_rd[d], $urandom);
    end
    check("fair_short", 32'(short_err), 32'(0));

    // Short transfer and err_clr
    request(1, 1'b1, $urandom);
    expect_grant(d);
    serve(d, 100, 1, 1'b1);
    check("short_set", 32'(short_err), 32'(1));
    repeat (5) tick();
    check("short_sticky", 32'(short_err), 32'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("short_clr", 32'(short_err), 32'(0));
    request(0, 1'b0, $urandom);
    expect_grant(d);
    serve(d, SB, 1, 1'b1);
    check("short_after_full", 32'(short_err), 32'(0));

    // Timeout while the host withholds ack for 40 cycles
    request(0, 1'b1, $urandom);
    expect_grant(d);
    wait_req(ok);
    if (ok) begin
      repeat (TO - 1) tick();
      check("timeout_early", 32'(timeout_err), 32'(0));
      tick();
      check("timeout_set", 32'(timeout_err), 32'(1));
      repeat (40 - TO) tick();
      check("timeout_rd_held", 32'(host_rd), 32'(1));
      serve(d, SB, 0, 1'b1);
      check("timeout_sticky", 32'(timeout_err), 32'(1));
      check("timeout_full_xfer", 32'(short_err), 32'(0));
    end

    // Stale request dropped one cycle after ack falls
    request(0, 1'b1, $urandom);
    expect_grant(d);
    serve(d, SB, 1, 1'b0);
    tick();
    dev_rd[0] = 1'b0;
    repeat (12) tick();
    check("stale_no_regrant", 32'(host_rd || host_wr), 32'(0));

    // Reset in the middle of a transfer
    request(0, 1'b1, $urandom);
    expect_grant(d);
    wait_req(ok);
    if (ok) begin
      exp_xfers.push_back('{dev: 0, nbytes: 200});
      tick();
      host_ack = 1'b1;
      tick();
      dev_rd[0] = 1'b0;
      request(1, 1'b1, $urandom);
      strobes(0, 200);
      host_din_strobe = 1'b1;
      reset = 1'b1;
      #1;
      check("rst_mid_ack",     32'(dev_ack), 32'(0));
      check("rst_mid_rdwr",    32'({host_rd, host_wr}), 32'(0));
      check("rst_mid_strobes", 32'(dev_din_strobe | dev_dout_strobe), 32'(0));
      check("rst_mid_errs",    32'({short_err, timeout_err}), 32'(0));
      tick(); tick();
      host_din_strobe = 1'b0;
      host_ack = 1'b0;
      reset = 1'b0;
      m_last = NDEV - 1;
      expect_grant(d);
      serve(d, 64, 0, 1'b1);
    end

    // Priority restarts at device 0 after reset
    request(0, 1'b0, $urandom);
    expect_grant(d);
    serve(d, 8, 0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_last = NDEV - 1;
    tick();
    check("rst_clears_short", 32'(short_err), 32'(0));
    request(0, 1'b1, $urandom);
    request(1, 1'b0, $urandom);
    expect_grant(d);
    serve(d, 8, 0, 1'b1);
    expect_grant(d);
    serve(d, 8, 0, 1'b1);

    repeat (6) tick();
    check("grants_left", 32'(exp_grants.size()), 32'(0));
    check("xfers_left",  32'(exp_xfers.size()),  32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_io_arbiter.md
Name: sd_io_arbiter

Overview:
- Shares one host sector-transfer channel between NUM_DEV sd_card emulator instances, for example several virtual drives behind a single host SPI sector path.
- Synchronizes each device's io_rd/io_wr requests, which originate in the sd_sck domain, into clk_sys.
- Grants one device at a time, round-robin, and forwards its LBA and request to the host.
- Routes the host ack and the byte strobes/data to the granted device only.
- Counts the sector bytes and reports sticky error flags.

Parameters:
- NUM_DEV, 2, number of sd_card requesters (1..4).
- SECTOR_BYTES, 512, bytes expected per transfer.
- TIMEOUT_CYCLES, 1048576, clk_sys cycles in REQ before timeout_err sets.

Ports:
- clk_sys  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- dev_rd  in  NUM_DEV  per-device sector read request (sd_sck domain, async to clk_sys).
- dev_wr  in  NUM_DEV  per-device sector write request (async).
- dev_lba  in  32*NUM_DEV  per-device LBA; device i occupies bits [32i+31:32i]; stable while its request is high.
- dev_ack  out  NUM_DEV  per-device io_ack.
- dev_dout  in  8*NUM_DEV  per-device byte read out of its buffer (write path).
- dev_din_strobe  out  NUM_DEV  write host byte into the device buffer.
- dev_dout_strobe  out  NUM_DEV  device buffer byte consumed.
- host_rd  out  1  sector read request to the host.
- host_wr  out  1  sector write request to the host.
- host_lba  out  32  LBA of the granted device.
- host_dev  out  $clog2(NUM_DEV) (minimum 1)  index of the granted device.
- host_ack  in  1  host transfer in progress.
- host_din_strobe  in  1  host byte valid for the device.
- host_dout_strobe  in  1  host consumed host_dout.
- host_dout  out  8  byte of the granted device.
- short_err  out  1  sticky: a transfer ended with byte count != SECTOR_BYTES.
- timeout_err  out  1  sticky: REQ exceeded TIMEOUT_CYCLES.
- err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async): state IDLE; all outputs 0; last_grant = NUM_DEV-1, so device 0 has first priority; synchronizers, counters and sticky flags cleared.
- Synchronization: 2-flop synchronizer on each dev_rd and dev_wr bit. dev_lba is sampled when the grant is made; it is quasi-static, so no synchronizer.
- FSM states: IDLE, REQ, XFER, RELEASE.
- IDLE:
  - Pending set = sync_rd | sync_wr.
  - Pick the first pending index searching from last_grant+1 with wrap.
  - On that edge: register grant, host_dev, host_lba, and host_rd = sync_rd[g] (rd wins if both set) or else host_wr; go to REQ.
  - Latency: host_rd/host_wr is high after the 3rd rising clk_sys edge following the dev_rd/dev_wr rise.
- REQ:
  - host_rd/host_wr held; timeout counter increments.
  - When the count reaches TIMEOUT_CYCLES, set timeout_err and keep waiting; no abort.
  - On host_ack=1: clear host_rd/host_wr, byte_cnt=0, go to XFER.
- XFER:
  - dev_ack[g]=1, registered; it rises one cycle after host_ack is seen.
  - dev_din_strobe[g] = host_din_strobe; dev_dout_strobe[g] = host_dout_strobe. Both are combinational and gated by state==XFER and grant.
  - host_dout = dev_dout[g] at all times; 0 when not in XFER.
  - byte_cnt increments on either strobe and saturates at SECTOR_BYTES. Strobes beyond that limit are still forwarded.
  - On host_ack=0: if byte_cnt != SECTOR_BYTES, set short_err; clear dev_ack; go to RELEASE.
- RELEASE:
  - Wait until sync_rd[g] and sync_wr[g] are both 0, to avoid re-granting a stale request.
  - Then last_grant=g and go to IDLE. Minimum 1 cycle.
- Invariants:
  - At most one dev_ack bit high.
  - Non-granted devices never see an ack or strobe.
  - host_rd and host_wr are never both high.
  - host_lba and host_dev are constant from IDLE exit until RELEASE exit.
- Simultaneous events:
  - A new request arriving during a grant waits.
  - err_clr in the same cycle as an error set: the set wins.
  - A host_ack glitch in IDLE/RELEASE is ignored.
- Reset mid-transfer: immediate return to IDLE. dev_ack falls asynchronously; the sd_card side keeps its own recovery.

Test Plan:
- Single read: dev_rd[0]=1, dev_lba[0]=0x1234; host acks 2 cycles after host_rd, issues 512 din strobes, drops ack -> host_rd=1 and host_lba=0x1234 at edge 3; dev_ack[0] high throughout XFER; 512 dev_din_strobe[0] pulses; dev_din_strobe[1]=0; short_err=0.
- Fairness: dev_rd[0] and dev_wr[1] asserted together and held re-asserted after each ack -> grants alternate 0,1,0,1; host_wr=1 only for dev 1; host_dout tracks dev_dout[1] during its XFER.
- Short transfer: host drops ack after 100 strobes -> short_err=1 and stays 1; err_clr pulse -> 0; next full 512-byte transfer leaves it 0.
- Timeout: with TIMEOUT_CYCLES=16 and host_ack withheld 40 cycles -> timeout_err=1 at cycle 16 of REQ; host_rd still 1; transfer completes normally afterwards.
- Reset mid-XFER: assert reset after 200 strobes -> dev_ack, host_rd, host_wr and all strobes 0 asynchronously; after release, a pending dev_rd[1] is served with device 1 first only if device 0 is idle (priority restarts at device 0).
- Stale request: sd_card drops dev_rd[0] late, 1 cycle after ack falls -> RELEASE holds until sync_rd[0]=0; no second grant to device 0.
